// File: rtl/spi_frame_arbiter_if.sv
// spi_frame_arbiter_if: frame requester, SPI byte port and MCU ack signals of the arbiter
interface spi_frame_arbiter_if #(
    parameter int LEN_W = 5
);
    logic [1:0]       req;
    logic [LEN_W-1:0] len0;
    logic [LEN_W-1:0] len1;
    logic [7:0]       byte0;
    logic [7:0]       byte1;
    logic [LEN_W-1:0] byte_idx;
    logic [1:0]       grant;
    logic [1:0]       done;
    logic [1:0]       timeout;
    logic             busy;
    logic [7:0]       spi_tx_byte;
    logic             spi_tx_dv;
    logic             spi_tx_ready;
    logic             mcu_ack;
    modport master (
        input  req, len0, len1, byte0, byte1, spi_tx_ready, mcu_ack,
        output byte_idx, grant, done, timeout, busy, spi_tx_byte, spi_tx_dv
    );
    modport slave (
        output req, len0, len1, byte0, byte1, spi_tx_ready, mcu_ack,
        input  byte_idx, grant, done, timeout, busy, spi_tx_byte, spi_tx_dv
    );
endinterface

// File: rtl/spi_frame_arbiter.sv
// spi_frame_arbiter: round-robin sharing of the SPI byte port between two frame requesters with MCU ack handshake
module spi_frame_arbiter #(
    parameter int MAX_LEN     = 16,
    parameter int LEN_W       = 5,
    parameter int ACK_TIMEOUT = 78000,
    parameter int TO_W        = 17
) (
    input  logic                clk_g_int_buf,
    input  logic                rstn_g_i,
    spi_frame_arbiter_if.master bus
);
    typedef enum logic [2:0] {IDLE, SEND, WAIT_RDY, ACK_WAIT, ACK_REL} state_t;
    localparam logic [LEN_W-1:0] MAX_L   = LEN_W'(MAX_LEN);
    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    state_t           state, state_n;
    logic [1:0]       grant, grant_n, done, done_n, timeout, timeout_n, ack_q;
    logic [LEN_W-1:0] idx, idx_n, len, len_n, len_sel, len_c;
    logic [TO_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [7:0]       tx_byte, byte_n, byte_sel;
    logic             tx_dv, dv_n, last, last_n, seen_low, seen_n, pend, pend_n, win, ack_s, to_hit;
    assign win      = (bus.req == 2'b10) | ((bus.req == 2'b11) & ~last);
    assign len_sel  = win ? bus.len1 : bus.len0;
    assign len_c    = (len_sel > MAX_L) ? MAX_L : len_sel;
    assign byte_sel = ((state == IDLE) ? win : grant[1]) ? bus.byte1 : bus.byte0;
    assign ack_s    = ack_q[1];
    assign to_hit   = cnt == TO_LAST;
    assign cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    assign bus.byte_idx    = idx;
    assign bus.grant       = grant;
    assign bus.done        = done;
    assign bus.timeout     = timeout;
    assign bus.busy        = state != IDLE;
    assign bus.spi_tx_byte = tx_byte;
    assign bus.spi_tx_dv   = tx_dv;
    // State and datapath registers; ack pin double-synchronised; reset drops dv/grant at once
    always_ff @(posedge clk_g_int_buf or negedge rstn_g_i) begin
        if (!rstn_g_i) begin
            state    <= IDLE;
            grant    <= '0;
            done     <= '0;
            timeout  <= '0;
            idx      <= '0;
            len      <= '0;
            cnt      <= '0;
            tx_byte  <= '0;
            tx_dv    <= 1'b0;
            last     <= 1'b1;
            seen_low <= 1'b0;
            pend     <= 1'b0;
            ack_q    <= '0;
        end else begin
            state    <= state_n;
            grant    <= grant_n;
            done     <= done_n;
            timeout  <= timeout_n;
            idx      <= idx_n;
            len      <= len_n;
            cnt      <= cnt_n;
            tx_byte  <= byte_n;
            tx_dv    <= dv_n;
            last     <= last_n;
            seen_low <= seen_n;
            pend     <= pend_n;
            ack_q    <= {ack_q[0], bus.mcu_ack};
        end
    end
    // Next-state: grant, byte streaming paced by ready edges, then ack rise/fall with per-phase timeout
    always_comb begin
        state_n   = state;
        grant_n   = grant;
        done_n    = '0;
        timeout_n = '0;
        idx_n     = idx;
        len_n     = len;
        cnt_n     = cnt;
        byte_n    = tx_byte;
        dv_n      = 1'b0;
        last_n    = last;
        seen_n    = seen_low;
        pend_n    = pend;
        case (state)
            IDLE: if (|bus.req && bus.spi_tx_ready) begin
                last_n = win;
                idx_n  = '0;
                if (len_c == '0) done_n = {win, ~win};
                else begin
                    grant_n = {win, ~win};
                    len_n   = len_c;
                    byte_n  = byte_sel;
                    dv_n    = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                seen_n  = 1'b0;
                state_n = WAIT_RDY;
            end
            WAIT_RDY: if (pend) begin
                pend_n  = 1'b0;
                byte_n  = byte_sel;
                dv_n    = 1'b1;
                state_n = SEND;
            end else if (!bus.spi_tx_ready) seen_n = 1'b1;
            else if (seen_low) begin
                seen_n = 1'b0;
                if (idx == len - 1'b1) begin
                    cnt_n   = '0;
                    state_n = ACK_WAIT;
                end else begin
                    idx_n  = idx + 1'b1;
                    pend_n = 1'b1;
                end
            end
            ACK_WAIT: if (ack_s) begin
                done_n  = grant;
                cnt_n   = '0;
                state_n = ACK_REL;
            end else if (to_hit) begin
                timeout_n = grant;
                grant_n   = '0;
                idx_n     = '0;
                state_n   = IDLE;
            end else cnt_n = cnt_inc;
            ACK_REL: if (!ack_s && bus.spi_tx_ready) begin
                grant_n = '0;
                idx_n   = '0;
                state_n = IDLE;
            end else if (to_hit) begin
                timeout_n = grant;
                grant_n   = '0;
                idx_n     = '0;
                state_n   = IDLE;
            end else cnt_n = cnt_inc;
            default: state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_spi_frame_arbiter.sv
// tb_spi_frame_arbiter: directed checks of streaming, round-robin, ack handshake, timeouts and async reset
module tb_spi_frame_arbiter;
    logic clk_g_int_buf = 1'b0;
    logic rstn_g_i = 1'b0;
    int n_chk = 0, n_fail = 0, cyc = 0, bad = 0;
    int done_cnt = 0, to_cnt = 0, done_cyc = 0, to_cyc = 0, rise_cyc = 0;
    logic [1:0] last_done = '0, last_to = '0;
    logic [7:0] q[$];
    logic [1:0] gq[$];
    always #5 clk_g_int_buf = ~clk_g_int_buf;
    spi_frame_arbiter_if #(.LEN_W(5)) bus ();
    spi_frame_arbiter #(.MAX_LEN(16), .LEN_W(5), .ACK_TIMEOUT(64), .TO_W(7)) dut (
        .clk_g_int_buf(clk_g_int_buf),
        .rstn_g_i(rstn_g_i),
        .bus(bus.master)
    );
    assign bus.byte0 = 8'hA0 + {3'b000, bus.byte_idx};
    assign bus.byte1 = 8'h50 + {3'b000, bus.byte_idx};
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic wait_bytes(input int n, input string tag);
        int k = 0;
        while (q.size() < n && k < 3000) begin
            @(negedge clk_g_int_buf);
            k++;
        end
        chk(tag, q.size(), n);
    endtask
    task automatic wait_done(input int n, input string tag);
        int k = 0;
        while (done_cnt < n && k < 3000) begin
            @(negedge clk_g_int_buf);
            k++;
        end
        chk(tag, done_cnt, n);
    endtask
    task automatic wait_to(input int n, input string tag);
        int k = 0;
        while (to_cnt < n && k < 3000) begin
            @(negedge clk_g_int_buf);
            k++;
        end
        chk(tag, to_cnt, n);
    endtask
    task automatic wait_idle(input string tag);
        int k = 0;
        while (bus.busy && k < 3000) begin
            @(negedge clk_g_int_buf);
            k++;
        end
        chk(tag, bus.busy, 0);
    endtask
    task automatic ack_frame(input logic [1:0] who, input string tag);
        int d0 = done_cnt;
        repeat (40) @(negedge clk_g_int_buf);
        bus.mcu_ack = 1'b1;
        wait_done(d0 + 1, {tag, "_done_cnt"});
        chk({tag, "_done_who"}, last_done, who);
        bus.mcu_ack = 1'b0;
        wait_idle({tag, "_idle"});
    endtask
    // Monitor a little after each rising edge: log bytes with their grant, pulse times, and one-hot violations
    always @(posedge clk_g_int_buf) begin
        #2;
        cyc++;
        if (bus.spi_tx_dv) begin
            q.push_back(bus.spi_tx_byte);
            gq.push_back(bus.grant);
        end
        if (bus.done != 2'b00) begin
            done_cnt++;
            last_done = bus.done;
            done_cyc = cyc;
        end
        if (bus.timeout != 2'b00) begin
            to_cnt++;
            last_to = bus.timeout;
            to_cyc = cyc;
        end
        if (!$onehot0(bus.grant) || !$onehot0(bus.done) || !$onehot0(bus.timeout) || (|bus.done && |bus.timeout)) bad++;
    end
    // SPI master model: ready drops for four cycles after each accepted byte
    initial begin
        bus.spi_tx_ready = 1'b1;
        forever begin
            @(negedge clk_g_int_buf);
            if (bus.spi_tx_dv) begin
                bus.spi_tx_ready = 1'b0;
                repeat (4) @(negedge clk_g_int_buf);
                bus.spi_tx_ready = 1'b1;
                rise_cyc = cyc;
            end
        end
    end
    initial begin
        int base, sz, d0, to0, k;
        logic [1:0] exp_g;
        bus.req = 2'b00;
        bus.len0 = 5'd8;
        bus.len1 = 5'd8;
        bus.mcu_ack = 1'b0;
        repeat (3) @(negedge clk_g_int_buf);
        chk("rst_grant", bus.grant, 0);
        chk("rst_dv", bus.spi_tx_dv, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_timeout", bus.timeout, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_byte", bus.spi_tx_byte, 0);
        chk("rst_idx", bus.byte_idx, 0);
        rstn_g_i = 1'b1;
        @(negedge clk_g_int_buf);
        // single eight-byte frame from requester 0
        bus.req = 2'b01;
        wait_bytes(1, "t1_first");
        bus.req = 2'b00;
        wait_bytes(8, "t1_count");
        for (int i = 0; i < 8; i++) begin
            chk("t1_byte", q[i], 8'hA0 + i);
            chk("t1_grant", gq[i], 2'b01);
        end
        ack_frame(2'b01, "t1");
        chk("t1_one_done", done_cnt, 1);
        // both requesting from reset: frames alternate 0,1,0 with no dv during ack
        rstn_g_i = 1'b0;
        bus.req = 2'b11;
        bus.len0 = 5'd2;
        bus.len1 = 5'd2;
        repeat (2) @(negedge clk_g_int_buf);
        rstn_g_i = 1'b1;
        for (int f = 0; f < 3; f++) begin
            exp_g = (f == 1) ? 2'b10 : 2'b01;
            base = q.size();
            wait_bytes(base + 2, "t2_bytes");
            if (f == 2) bus.req = 2'b00;
            chk("t2_grant", gq[base], exp_g);
            chk("t2_byte0", q[base], (f == 1) ? 8'h50 : 8'hA0);
            chk("t2_byte1", q[base + 1], (f == 1) ? 8'h51 : 8'hA1);
            sz = q.size();
            ack_frame(exp_g, "t2");
            chk("t2_no_dv_in_ack", q.size(), sz);
        end
        // ack never rises: timeout 64 cycles after ACK_WAIT entry (entry is the edge after ready rises)
        bus.len0 = 5'd1;
        bus.req = 2'b01;
        base = q.size();
        d0 = done_cnt;
        to0 = to_cnt;
        wait_bytes(base + 1, "t3_byte");
        bus.req = 2'b00;
        wait_to(to0 + 1, "t3_to_cnt");
        chk("t3_to_who", last_to, 2'b01);
        chk("t3_to_delay", to_cyc - (rise_cyc + 1), 64);
        chk("t3_no_done", done_cnt, d0);
        @(negedge clk_g_int_buf);
        chk("t3_busy", bus.busy, 0);
        chk("t3_grant", bus.grant, 0);
        // ack stuck high: done, then release-phase timeout 64 cycles later, then a fresh grant
        bus.req = 2'b01;
        base = q.size();
        to0 = to_cnt;
        wait_bytes(base + 1, "t4_byte");
        bus.req = 2'b00;
        repeat (10) @(negedge clk_g_int_buf);
        bus.mcu_ack = 1'b1;
        wait_done(done_cnt + 1, "t4_done");
        chk("t4_done_who", last_done, 2'b01);
        wait_to(to0 + 1, "t4_to_cnt");
        chk("t4_to_who", last_to, 2'b01);
        chk("t4_to_delay", to_cyc - done_cyc, 64);
        bus.mcu_ack = 1'b0;
        @(negedge clk_g_int_buf);
        bus.req = 2'b01;
        k = 0;
        while (bus.grant == 2'b00 && k < 200) begin
            @(negedge clk_g_int_buf);
            k++;
        end
        chk("t4_regrant", bus.grant, 2'b01);
        bus.req = 2'b00;
        ack_frame(2'b01, "t4");
        // zero-length frame from requester 1, then the pointer favours requester 0
        bus.len1 = 5'd0;
        bus.req = 2'b10;
        sz = q.size();
        d0 = done_cnt;
        k = 0;
        while (done_cnt == d0 && k < 200) begin
            @(negedge clk_g_int_buf);
            k++;
        end
        bus.req = 2'b00;
        chk("t5_done_cnt", done_cnt, d0 + 1);
        chk("t5_done_who", last_done, 2'b10);
        repeat (5) @(negedge clk_g_int_buf);
        chk("t5_no_dv", q.size(), sz);
        chk("t5_busy", bus.busy, 0);
        bus.len0 = 5'd1;
        bus.len1 = 5'd1;
        bus.req = 2'b11;
        k = 0;
        while (bus.grant == 2'b00 && k < 200) begin
            @(negedge clk_g_int_buf);
            k++;
        end
        chk("t5_rr_favours0", bus.grant, 2'b01);
        bus.req = 2'b00;
        ack_frame(2'b01, "t5");
        // async reset while byte 3 is on the bus; frame restarts from idx 0
        bus.len0 = 5'd8;
        bus.req = 2'b01;
        base = q.size();
        wait_bytes(base + 3, "t6_three");
        #1 rstn_g_i = 1'b0;
        #1;
        chk("t6_async_dv", bus.spi_tx_dv, 0);
        chk("t6_async_grant", bus.grant, 0);
        @(negedge clk_g_int_buf);
        rstn_g_i = 1'b1;
        base = q.size();
        wait_bytes(base + 1, "t6_restart");
        bus.req = 2'b00;
        wait_bytes(base + 8, "t6_count");
        chk("t6_first", q[base], 8'hA0);
        chk("t6_third", q[base + 2], 8'hA2);
        chk("t6_last", q[base + 7], 8'hA7);
        ack_frame(2'b01, "t6");
        repeat (10) @(negedge clk_g_int_buf);
        chk("t6_no_extra", q.size(), base + 8);
        chk("one_hot", bad, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
